// File: rtl/eth_phy_link_pkg.sv
// Shared definitions for the eth_phy_10g link bring-up sequencer:
// state encoding, XGMII idle pattern and a small sizing helper.
package eth_phy_link_pkg;

  localparam logic [2:0] LS_IDLE        = 3'd0;
  localparam logic [2:0] LS_RST         = 3'd1;
  localparam logic [2:0] LS_WAIT_LOCK   = 3'd2;
  localparam logic [2:0] LS_WAIT_STATUS = 3'd3;
  localparam logic [2:0] LS_UP          = 3'd4;
  localparam logic [2:0] LS_DOWN        = 3'd5;
  localparam logic [2:0] LS_PRBS        = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE        = LS_IDLE,
    ST_RST         = LS_RST,
    ST_WAIT_LOCK   = LS_WAIT_LOCK,
    ST_WAIT_STATUS = LS_WAIT_STATUS,
    ST_UP          = LS_UP,
    ST_DOWN        = LS_DOWN,
    ST_PRBS        = LS_PRBS
  } link_state_e;

  localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;

  // Larger of two values, used to size the shared state timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_phy_link_txgate.sv
// Registered XGMII TX gate: passes MAC data to the PHY only when the
// sequencer is about to be (or stay) in UP, otherwise sends idles.
module eth_phy_link_txgate
  import eth_phy_link_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_up_next,
  input  logic [DATA_WIDTH-1:0] mac_txd,
  input  logic [CTRL_WIDTH-1:0] mac_txc,
  output logic [DATA_WIDTH-1:0] phy_txd,
  output logic [CTRL_WIDTH-1:0] phy_txc
);

  // One-cycle mux register; idles on reset and whenever the link is not up.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      phy_txd <= DATA_WIDTH'(XGMII_IDLE_D);
      phy_txc <= CTRL_WIDTH'(XGMII_IDLE_C);
    end else if (link_up_next) begin
      phy_txd <= mac_txd;
      phy_txc <= mac_txc;
    end else begin
      phy_txd <= DATA_WIDTH'(XGMII_IDLE_D);
      phy_txc <= CTRL_WIDTH'(XGMII_IDLE_C);
    end
  end

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// Link bring-up sequencer for eth_phy_10g: serdes reset with lock timeout,
// stable-status qualification, link-down accounting and TX idle gating.
// Optional PRBS31 check before link-up: define ETH_PHY_LINK_CTRL_PRBS_CHECK_EN.
module eth_phy_10g_link_ctrl
  import eth_phy_link_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = 8,
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int STATUS_TIMEOUT = 65536,
  parameter int PRBS_CYCLES    = 1024,
  parameter int PRBS_MAX_ERR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] mac_xgmii_txd,
  input  logic [CTRL_WIDTH-1:0] mac_xgmii_txc,
  output logic [DATA_WIDTH-1:0] phy_xgmii_txd,
  output logic [CTRL_WIDTH-1:0] phy_xgmii_txc,
  input  logic                  phy_rx_block_lock,
  input  logic                  phy_rx_high_ber,
  input  logic                  phy_rx_status,
  input  logic [6:0]            phy_rx_error_count,
  output logic                  phy_rx_reset_req,
  output logic                  cfg_prbs31_enable,
  output logic                  link_up,
  output logic [2:0]            link_state,
  output logic [7:0]            retry_count,
  output logic [15:0]           link_down_count
);

  localparam int TIMER_MAX = max2(max2(RESET_CYCLES, LOCK_TIMEOUT),
                                  max2(STATUS_TIMEOUT, PRBS_CYCLES));
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int STABLE_W  = $clog2(STABLE_CYCLES + 1);

`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
  localparam link_state_e ST_QUALIFIED = ST_PRBS;
`else
  localparam link_state_e ST_QUALIFIED = ST_UP;
`endif

  link_state_e         state, state_next;
  logic [TIMER_W-1:0]  timer;
  logic [STABLE_W-1:0] stable;
  logic                retry_inc, down_inc;
  logic                status_good, timed_state;

  assign status_good = phy_rx_status && !phy_rx_high_ber;
  assign timed_state = (state == ST_RST) || (state == ST_WAIT_LOCK) ||
                       (state == ST_WAIT_STATUS) || (state == ST_PRBS);

`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
  logic [6:0] prbs_snap;
  logic [6:0] prbs_delta;
  // 7-bit subtraction gives the error-count increase modulo 128.
  assign prbs_delta = phy_rx_error_count - prbs_snap;
`else
  logic unused_prbs;
  assign unused_prbs = ^{phy_rx_error_count, 32'(PRBS_CYCLES), 32'(PRBS_MAX_ERR)};
`endif

  // Next-state decode; qualifying events are tested before timeouts.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    retry_inc  = 1'b0;
    down_inc   = 1'b0;
    if (!cfg_enable) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_next = ST_RST;
        ST_RST: begin
          if (timer == TIMER_W'(RESET_CYCLES - 1)) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (phy_rx_block_lock) begin
            state_next = ST_WAIT_STATUS;
          end else if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
            state_next = ST_RST;
            retry_inc  = 1'b1;
          end
        end
        ST_WAIT_STATUS: begin
          if (!phy_rx_block_lock) begin
            state_next = ST_WAIT_LOCK;
          end else if (status_good && stable == STABLE_W'(STABLE_CYCLES - 1)) begin
            state_next = ST_QUALIFIED;
          end else if (timer == TIMER_W'(STATUS_TIMEOUT - 1)) begin
            state_next = ST_RST;
            retry_inc  = 1'b1;
          end
        end
        ST_UP: begin
          if (!phy_rx_status || !phy_rx_block_lock) begin
            state_next = ST_DOWN;
            down_inc   = 1'b1;
          end
        end
        ST_DOWN: state_next = ST_WAIT_LOCK;
`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
        ST_PRBS: begin
          if (!phy_rx_block_lock) begin
            state_next = ST_WAIT_LOCK;
          end else if (timer == TIMER_W'(PRBS_CYCLES - 1)) begin
            if (32'(prbs_delta) > 32'(PRBS_MAX_ERR)) begin
              state_next = ST_RST;
              retry_inc  = 1'b1;
            end else begin
              state_next = ST_UP;
            end
          end
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register, per-state timer (cleared on entry) and stable-run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      timer  <= '0;
      stable <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || !timed_state) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
      if (state == ST_WAIT_STATUS && state_next == ST_WAIT_STATUS && status_good) begin
        stable <= stable + STABLE_W'(1);
      end else begin
        stable <= '0;
      end
    end
  end

  // Saturating retry and link-down counters; they hold across disable.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_count     <= '0;
      link_down_count <= '0;
    end else begin
      if (retry_inc && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      if (down_inc && link_down_count != 16'hFFFF) link_down_count <= link_down_count + 16'd1;
    end
  end

`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
  // Error-count snapshot taken on entry into the PRBS window.
  always_ff @(posedge clk) begin
    if (rst) begin
      prbs_snap <= '0;
    end else if (state_next == ST_PRBS && state != ST_PRBS) begin
      prbs_snap <= phy_rx_error_count;
    end
  end
  assign cfg_prbs31_enable = (state == ST_PRBS);
`else
  assign cfg_prbs31_enable = 1'b0;
`endif

  assign link_up          = (state == ST_UP);
  assign link_state       = state;
  assign phy_rx_reset_req = (state == ST_RST) && cfg_enable;

  eth_phy_link_txgate #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_txgate (
    .clk          (clk),
    .rst          (rst),
    .link_up_next (state_next == ST_UP),
    .mac_txd      (mac_xgmii_txd),
    .mac_txc      (mac_xgmii_txc),
    .phy_txd      (phy_xgmii_txd),
    .phy_txc      (phy_xgmii_txc)
  );

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Self-checking bench for eth_phy_10g_link_ctrl: directed bring-up scenarios
// followed by randomized stimulus, all compared against a behavioural model.
module tb_eth_phy_10g_link_ctrl;

  localparam int RC  = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int STO = 50;
  localparam int PC  = 12;
  localparam int PME = 0;
`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
  localparam int QUAL = SC + PC;
`else
  localparam int QUAL = SC;
`endif

  localparam int S_IDLE = 0, S_RST = 1, S_WL = 2, S_WS = 3, S_UP = 4, S_DOWN = 5, S_PRBS = 6;
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;

  logic        clk = 1'b0;
  logic        rst, cfg_enable;
  logic [63:0] mac_xgmii_txd, phy_xgmii_txd;
  logic [7:0]  mac_xgmii_txc, phy_xgmii_txc;
  logic        phy_rx_block_lock, phy_rx_high_ber, phy_rx_status;
  logic [6:0]  phy_rx_error_count;
  logic        phy_rx_reset_req, cfg_prbs31_enable, link_up;
  logic [2:0]  link_state;
  logic [7:0]  retry_count;
  logic [15:0] link_down_count;

  always #5 clk = ~clk;

  eth_phy_10g_link_ctrl #(
    .DATA_WIDTH (64), .CTRL_WIDTH (8),
    .RESET_CYCLES (RC), .LOCK_TIMEOUT (LT), .STABLE_CYCLES (SC),
    .STATUS_TIMEOUT (STO), .PRBS_CYCLES (PC), .PRBS_MAX_ERR (PME)
  ) dut (
    .clk (clk), .rst (rst), .cfg_enable (cfg_enable),
    .mac_xgmii_txd (mac_xgmii_txd), .mac_xgmii_txc (mac_xgmii_txc),
    .phy_xgmii_txd (phy_xgmii_txd), .phy_xgmii_txc (phy_xgmii_txc),
    .phy_rx_block_lock (phy_rx_block_lock), .phy_rx_high_ber (phy_rx_high_ber),
    .phy_rx_status (phy_rx_status), .phy_rx_error_count (phy_rx_error_count),
    .phy_rx_reset_req (phy_rx_reset_req), .cfg_prbs31_enable (cfg_prbs31_enable),
    .link_up (link_up), .link_state (link_state),
    .retry_count (retry_count), .link_down_count (link_down_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: current state, cycles spent in it, good-status run.
  int          m_st, m_tmr, m_stable, m_retry, m_downs, m_snap;
  logic [63:0] m_txd;
  logic [7:0]  m_txc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the rules of the bring-up sequence to the inputs seen at this edge.
  task automatic model_step();
    int nxt;
    bit rinc, dinc, good;
    if (rst) begin
      m_st = S_IDLE; m_tmr = 0; m_stable = 0; m_retry = 0; m_downs = 0; m_snap = 0;
      m_txd = IDLE_D; m_txc = IDLE_C;
      return;
    end
    nxt = m_st; rinc = 0; dinc = 0;
    good = phy_rx_status && !phy_rx_high_ber;
    if (!cfg_enable) nxt = S_IDLE;
    else case (m_st)
      S_IDLE: nxt = S_RST;
      S_RST:  if (m_tmr == RC - 1) nxt = S_WL;
      S_WL: begin
        if (phy_rx_block_lock) nxt = S_WS;
        else if (m_tmr == LT - 1) begin nxt = S_RST; rinc = 1; end
      end
      S_WS: begin
        if (!phy_rx_block_lock) nxt = S_WL;
`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
        else if (good && m_stable + 1 == SC) nxt = S_PRBS;
`else
        else if (good && m_stable + 1 == SC) nxt = S_UP;
`endif
        else if (m_tmr == STO - 1) begin nxt = S_RST; rinc = 1; end
      end
      S_UP: if (!phy_rx_status || !phy_rx_block_lock) begin nxt = S_DOWN; dinc = 1; end
      S_DOWN: nxt = S_WL;
      S_PRBS: begin
        if (!phy_rx_block_lock) nxt = S_WL;
        else if (m_tmr == PC - 1) begin
          if (((int'(phy_rx_error_count) - m_snap) & 127) > PME) begin nxt = S_RST; rinc = 1; end
          else nxt = S_UP;
        end
      end
      default: nxt = S_IDLE;
    endcase
    m_stable = (m_st == S_WS && nxt == S_WS && good) ? m_stable + 1 : 0;
    if (nxt == S_PRBS && m_st != S_PRBS) m_snap = int'(phy_rx_error_count);
    m_tmr = (nxt == m_st) ? m_tmr + 1 : 0;
    if (rinc && m_retry < 255) m_retry++;
    if (dinc && m_downs < 65535) m_downs++;
    m_txd = (nxt == S_UP) ? mac_xgmii_txd : IDLE_D;
    m_txc = (nxt == S_UP) ? mac_xgmii_txc : IDLE_C;
    m_st = nxt;
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs after the edge.
  task automatic tick(input bit r, input bit en, input bit lk, input bit ber, input bit st);
    rst = r; cfg_enable = en; phy_rx_block_lock = lk; phy_rx_high_ber = ber; phy_rx_status = st;
    mac_xgmii_txd = {$urandom, $urandom};
    mac_xgmii_txc = 8'($urandom);
    @(posedge clk);
    model_step();
    #1;
    check("link_state", 64'(link_state), 64'(m_st));
    check("link_up", 64'(link_up), 64'(m_st == S_UP));
    check("reset_req", 64'(phy_rx_reset_req), 64'(m_st == S_RST && cfg_enable));
`ifdef ETH_PHY_LINK_CTRL_PRBS_CHECK_EN
    check("prbs_en", 64'(cfg_prbs31_enable), 64'(m_st == S_PRBS));
`else
    check("prbs_en", 64'(cfg_prbs31_enable), 64'd0);
`endif
    check("retry_count", 64'(retry_count), 64'(m_retry));
    check("link_down_count", 64'(link_down_count), 64'(m_downs));
    check("phy_txd", phy_xgmii_txd, m_txd);
    check("phy_txc", 64'(phy_xgmii_txc), 64'(m_txc));
  endtask

  initial begin
    int req_cycles, up_at;
    rst = 1'b1; cfg_enable = 1'b0; phy_rx_block_lock = 1'b0; phy_rx_high_ber = 1'b0;
    phy_rx_status = 1'b0; phy_rx_error_count = 7'd0;
    mac_xgmii_txd = '0; mac_xgmii_txc = '0;

    // Reset state.
    repeat (3) tick(1, 0, 0, 0, 0);
    check("rst_txd_idle", phy_xgmii_txd, IDLE_D);
    check("rst_state_idle", 64'(link_state), 64'(S_IDLE));

    // 1: clean bring-up with lock and status high.
    req_cycles = 0; up_at = -1;
    for (int i = 1; i <= 60 && up_at < 0; i++) begin
      tick(0, 1, 1, 0, 1);
      if (phy_rx_reset_req) req_cycles++;
      if (link_up) up_at = i;
    end
    check("s1_reset_req_cycles", 64'(req_cycles), 64'(RC));
    check("s1_link_up_edge", 64'(up_at), 64'(1 + RC + 1 + QUAL));
    repeat (5) tick(0, 1, 1, 0, 1);

    // 3: one-cycle status drop in UP, then requalify.
    tick(0, 1, 1, 0, 0);
    check("s3_down_state", 64'(link_state), 64'(S_DOWN));
    check("s3_down_count", 64'(link_down_count), 64'd1);
    up_at = -1;
    for (int i = 1; i <= 60 && up_at < 0; i++) begin
      tick(0, 1, 1, 0, 1);
      if (link_up) up_at = i;
    end
    check("s3_relock_edge", 64'(up_at), 64'(2 + QUAL));

    // 4: lock drop, then a status glitch at the 5th WAIT_STATUS cycle.
    tick(0, 1, 0, 0, 1);
    tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 1);
    check("s4_in_wait_status", 64'(link_state), 64'(S_WS));
    repeat (4) tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 0);
    up_at = -1;
    for (int i = 1; i <= 40 && up_at < 0; i++) begin
      tick(0, 1, 1, 0, 1);
      if (link_up) up_at = i;
    end
    check("s4_glitch_restart", 64'(up_at), 64'(QUAL));
    // High BER holds WAIT_STATUS even with status high.
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 1);
    repeat (30) tick(0, 1, 1, 1, 1);
    check("s4_high_ber_blocks", 64'(link_state), 64'(S_WS));
    repeat (QUAL) tick(0, 1, 1, 0, 1);
    check("s4_up_after_ber", 64'(link_up), 64'd1);

    // 5: disable in UP holds counters; rst mid-RST clears them.
    tick(0, 0, 1, 0, 1);
    check("s5_disable_idle", 64'(link_state), 64'(S_IDLE));
    check("s5_downs_held", 64'(link_down_count), 64'd3);
    tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 1);
    check("s5_in_rst", 64'(phy_rx_reset_req), 64'd1);
    tick(1, 1, 1, 0, 1);
    check("s5_rst_clears_downs", 64'(link_down_count), 64'd0);
    check("s5_rst_req_low", 64'(phy_rx_reset_req), 64'd0);

    // Boundary: lock arrives on the last WAIT_LOCK cycle -> progress, no retry.
    repeat (1 + RC + LT - 1) tick(0, 1, 0, 0, 1);
    tick(0, 1, 1, 0, 1);
    check("b_lock_wins", 64'(link_state), 64'(S_WS));
    check("b_lock_no_retry", 64'(retry_count), 64'd0);
    // Boundary: stable completes on the last WAIT_STATUS cycle -> progress.
    repeat (STO - SC) tick(0, 1, 1, 0, 0);
    repeat (SC) tick(0, 1, 1, 0, 1);
    check("b_stable_wins", 64'(link_state), 64'(QUAL == SC ? S_UP : S_PRBS));
    check("b_stable_no_retry", 64'(retry_count), 64'd0);

    // 2: no lock -> periodic retries, then saturation at 255.
    tick(1, 0, 0, 0, 0);
    repeat (1 + 3 * (RC + LT) + 4) tick(0, 1, 0, 0, 0);
    check("s2_three_retries", 64'(retry_count), 64'd3);
    repeat (256 * (RC + LT)) tick(0, 1, 0, 0, 0);
    check("s2_retry_saturates", 64'(retry_count), 64'd255);

    // Randomized stimulus with biased flags.
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) phy_rx_error_count = 7'($urandom);
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 98,
           $urandom_range(0, 99) < 96, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 95);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
